mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single shared memory port of the multicycle CPU.
- Port 0 is the CPU's memory access (instruction or data, already muxed by the CPU). Port 1 is a loader/DMA requester.
- Serialises accesses, inserts memory wait states and returns a one-cycle acknowledge per transaction. The CPU FSM stalls in any memory-using state while p0_req is high and p0_ack is low.

Parameters:
AW, 32, address width
DW, 32, data width
LAT, 1, memory access cycles per transaction (>=1); mem_rdata valid in the LAT-th mem_en cycle
RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
p0_req  in  1  port 0 request; hold with addr/we/wdata stable until p0_ack
p0_we  in  1  port 0 write enable
p0_addr  in  AW  port 0 address
p0_wdata  in  DW  port 0 write data
p0_rdata  out  DW  port 0 read data, registered, valid from p0_ack cycle until next p0_ack
p0_ack  out  1  port 0 one-cycle completion pulse
p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_ack  same widths and roles for port 1
mem_en  out  1  memory enable
mem_we  out  1  memory write strobe
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data
busy  out  1  high in any non-IDLE state

Behaviour:
- FSM states: IDLE, BUSY, ACK.
- IDLE, no req: stay. mem_en=0, mem_we=0.
- IDLE, any req: pick winner and latch it with its addr/we/wdata into internal registers; load cnt=LAT-1; go to BUSY.
  - Single request: that port wins.
  - Both, RR=1: the port not served last wins. Pointer resets so port 0 wins the first tie.
  - Both, RR=0: port 0 wins.
- BUSY:
  - mem_en=1; mem_addr/mem_wdata driven from the latched registers, stable for all LAT cycles.
  - cnt decrements each cycle.
  - On the cycle with cnt==0: mem_we=latched we (a single write strobe). If it is a read, capture mem_rdata into the winner's rdata register. Then go to ACK.
- ACK:
  - winner's ack=1 for exactly one cycle; mem_en=0.
  - Update the last-served pointer; go to IDLE.
- Latency: req sampled in IDLE at cycle t gives ack at cycle t+LAT+1. Throughput is one transaction per LAT+2 cycles.
- req still high in the cycle after ack is a new transaction. Requesters must drop req or change it in that cycle.
- Losing port: its req stays pending, no ack, and its rdata register is unchanged.
- Requester drops req mid-transaction: the transaction still completes, including the write, and ack still pulses.
- Requester changes addr/wdata mid-transaction: ignored, because the latched copy is used.
- p0_ack and p1_ack are never high in the same cycle. mem_we is never high unless mem_en is high.
- Reset, including reset asserted mid-BUSY:
  - State goes to IDLE; cnt=0; acks=0; mem_en=0; mem_we=0.
  - mem_addr=0, mem_wdata=0, p0_rdata=0, p1_rdata=0, busy=0.
  - The pointer is set so port 0 wins the next tie.
  - An interrupted write is not completed and issues no strobe after reset.
- cnt width is clog2(LAT)+1. For LAT=1, BUSY lasts exactly one cycle.

Decomposition:
- Shared package: FSM state encodings (IDLE=2'b00, BUSY=2'b01, ACK=2'b10) and port-index constants (PORT_CPU=0, PORT_DMA=1).
- One sub-module, rr_arb2: combinational two-way picker.
  - Inputs: req[1:0], last, rr_en.
  - Output: a one-hot grant.
  - The pointer register stays in mem_arbiter.

Test Plan:
- LAT=1, p0 read addr 0x10, mem returns 0xDEADBEEF: mem_en high one cycle at t+1; p0_ack at t+2; p0_rdata=0xDEADBEEF and held afterwards; p1_ack stays 0.
- LAT=3, p1 write addr 0x20 data 0x1234: mem_en high 3 cycles with addr 0x20; mem_we high only on the 3rd; p1_ack at t+4.
- RR=1, both req held continuously: acks alternate p0,p1,p0,p1, starting with p0 after reset, one ack every LAT+2 cycles.
- RR=0, both req held continuously: only p0_ack pulses; p1 is starved until p0 drops req, then p1_ack follows.
- p0 changes addr from 0x10 to 0x40 in the middle of BUSY (LAT=3): mem_addr stays 0x10 throughout the transaction.
- rst asserted in the 2nd BUSY cycle of a LAT=3 write: mem_en/mem_we drop immediately; no ack; no write strobe occurs; the next tie grants p0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and port indices.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    ACK  = 2'b10
  } state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports, the shared memory port and debug state for mem_arbiter.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);
  // Handshake: a requester raises pN_req with we/addr/wdata stable and holds them
  // until pN_ack, a single-cycle pulse. pN_rdata is valid from that ack cycle
  // until the port's next ack. req still high the cycle after ack is a new request.
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p0_rdata;
  logic          p0_ack;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] p1_rdata;
  logic          p1_ack;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic          busy;
  state_t        state_dbg;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_rdata, p0_ack, p1_rdata, p1_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, state_dbg
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_rdata, p0_ack, p1_rdata, p1_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, state_dbg
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Combinational two-way picker: one-hot grant from two requests and the last-served port.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port not served last wins; without rotation the CPU always wins.
      2'b11:   grant = (rr_en && (last == PORT_CPU)) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises CPU and DMA accesses onto one memory port, inserting LAT wait cycles
// per transaction and returning a one-cycle ack to the winning requester.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1,
  parameter int RR  = 1
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  localparam int             CW       = $clog2(LAT) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
  localparam logic           RR_EN    = (RR != 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          win;
  logic          lat_we;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q;
  logic [DW-1:0] rdata1_q;
  logic          ack0_q;
  logic          ack1_q;
  logic          en_q;
  logic          we_q;
  logic          busy_q;

  logic [1:0]    req;
  logic [1:0]    grant;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req = {bus.p1_req, bus.p0_req};

  rr_arb2 u_pick (
    .req   (req),
    .last  (last),
    .rr_en (RR_EN),
    .grant (grant)
  );

  assign sel_we    = grant[1] ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = grant[1] ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant[1] ? bus.p1_wdata : bus.p0_wdata;

  // The write strobe is registered one cycle ahead so it lands on the cnt==0 cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      last     <= PORT_DMA;
      win      <= PORT_CPU;
      lat_we   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != 2'b00) begin
            win     <= grant[1];
            lat_we  <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= CNT_LOAD;
            en_q    <= 1'b1;
            we_q    <= sel_we && (CNT_LOAD == '0);
            busy_q  <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (win == PORT_DMA) rdata1_q <= bus.mem_rdata;
              else                 rdata0_q <= bus.mem_rdata;
            end
            en_q   <= 1'b0;
            we_q   <= 1'b0;
            ack0_q <= (win == PORT_CPU);
            ack1_q <= (win == PORT_DMA);
            state  <= ACK;
          end else begin
            cnt  <= cnt - CW'(1);
            we_q <= lat_we && (cnt == CW'(1));
          end
        end
        ACK: begin
          last   <= win;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.p0_rdata  = rdata0_q;
  assign bus.p1_rdata  = rdata1_q;
  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.state_dbg = state;

endmodule
